line_sequencer: RTL and testbench
=================================

LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: DEPTH, default 4, request FIFO depth (power of two, at least 2).
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: req_valid  in  1  line request offered.
REQ-006 Port: req_ready  out  1  request FIFO can accept.
REQ-007 Port: req_x0, req_y0, req_x1, req_y1  in  11 each  line endpoints.
REQ-008 Port: req_color  in  1  pixel colour for the line (1 = draw, 0 = erase).
REQ-009 Port: ld_reset  out  1  start pulse to the downstream line drawer.
REQ-010 Port: ld_x0, ld_y0, ld_x1, ld_y1  out  11 each  endpoints to the drawer.
REQ-011 Port: ld_x, ld_y  in  11 each  current pixel from the drawer.
REQ-012 Port: ld_finished  in  1  drawer done flag.
REQ-013 Port: pix_valid  out  1  pixel write strobe to the framebuffer.
REQ-014 Port: pix_x, pix_y  out  11 each  pixel address.
REQ-015 Port: pix_color  out  1  pixel colour.
REQ-016 Port: busy  out  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-017 A request SHALL be accepted on any rising edge where req_valid and req_ready are both high; the endpoints and colour are then pushed into the FIFO.
REQ-018 req_ready SHALL equal "FIFO not full" and SHALL NOT depend on a pop in the same cycle.
REQ-019 The FSM SHALL have exactly three states: IDLE, LOAD and DRAW.
REQ-020 In IDLE with the FIFO non-empty, on the next edge the head entry SHALL be popped into the current-line registers and the state SHALL become LOAD.
REQ-021 In LOAD, ld_reset SHALL be 1 and ld_* SHALL present the current-line registers; on the next edge the state SHALL become DRAW.
REQ-022 ld_x0..ld_y1 SHALL remain constant from LOAD until the line leaves DRAW.
REQ-023 In DRAW, pix_valid SHALL be high exactly when ld_finished is 0.
REQ-024 pix_x and pix_y SHALL equal ld_x and ld_y combinationally; pix_color SHALL be the current-line colour.
REQ-025 In DRAW with ld_finished=1: if the FIFO is non-empty, pop the head and go directly to LOAD; otherwise go to IDLE.
REQ-026 Latency: for a request accepted at edge N into an empty, idle block, LOAD SHALL occupy the cycle after edge N+1, and the first pix_valid SHALL occur in the cycle after edge N+2.
REQ-027 Back-to-back lines SHALL have exactly 2 non-valid cycles (finished, LOAD) between the last pixel of one line and the first pixel of the next.
REQ-028 A zero-length line (x0=x1, y0=y1) SHALL emit exactly one pixel.
REQ-029 A push and a pop in the same cycle SHALL leave the FIFO count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 pix_valid SHALL be 0 in IDLE and in LOAD.

Reset
REQ-031 During reset: state SHALL be IDLE, the FIFO SHALL be emptied, and the current-line registers SHALL be 0.
REQ-032 During reset: pix_valid=0, busy=0, and req_ready SHALL be 1 from the first cycle after reset.
REQ-033 ld_reset SHALL be 1 whenever reset is 1, so the drawer is also reset.
REQ-034 A reset during DRAW SHALL abandon the line and the queued requests with no further pix_valid.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the coordinate width (11), and the packed line-request struct {x0, y0, x1, y1, color}.
REQ-036 The FIFO SHALL be a sub-module, line_req_fifo, parameterised by DEPTH and the request struct type.

Verification
REQ-037 Request (0,0)->(3,0), colour 1, with the drawer attached -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles starting 2 edges after acceptance, then pix_valid=0 and busy=0.
REQ-038 Request (3,3)->(0,0) immediately followed by request (5,0)->(2,2) -> pixels (0,0)..(3,3), then 2 gap cycles, then (2,2),(3,1),(4,0),(5,0).
REQ-039 Request (7,7)->(7,7) -> exactly one pixel (7,7).
REQ-040 While drawing (0,0)->(100,0), push DEPTH more requests -> req_ready=0 after the DEPTH-th push; all lines are later drawn in FIFO order with the correct colours.
REQ-041 Assert reset mid-line while 2 requests are queued -> pix_valid=0 from the reset cycle onward, ld_reset=1 during reset, busy=0 and req_ready=1 after reset.

Source files
------------

// File: rtl/line_sequencer_pkg.sv
// Shared types for the line sequencer: FSM states, coordinate width and
// the packed line-request record carried through the request FIFO.
package line_sequencer_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic               color;
  } line_req_t;

  localparam int LINE_REQ_W = $bits(line_req_t);

endpackage

// File: rtl/line_req_fifo.sv
// Small synchronous FIFO holding pending line requests. Head entry is
// visible combinationally on pop_data; pointers wrap modulo DEPTH.
module line_req_fifo
  import line_sequencer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = line_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  ZERO_COUNT = {(PTR_W+1){1'b0}};

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_COUNT;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign full     = (count_r == FULL_COUNT);
  assign empty    = (count_r == ZERO_COUNT);
  assign pop_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/line_sequencer.sv
// Queues line requests and feeds them one at a time to an external line
// drawer, forwarding the drawer's pixels as framebuffer write strobes.
module line_sequencer
  import line_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_x0,
  input  logic [COORD_W-1:0] req_y0,
  input  logic [COORD_W-1:0] req_x1,
  input  logic [COORD_W-1:0] req_y1,
  input  logic               req_color,
  output logic               ld_reset,
  output logic [COORD_W-1:0] ld_x0,
  output logic [COORD_W-1:0] ld_y0,
  output logic [COORD_W-1:0] ld_x1,
  output logic [COORD_W-1:0] ld_y1,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  input  logic               ld_finished,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_color,
  output logic               busy
);

  state_t    state_r;
  state_t    state_s;
  line_req_t cur_r;
  line_req_t push_data_s;
  line_req_t head_s;
  logic      push_s;
  logic      pop_s;
  logic      full_s;
  logic      empty_s;

  assign push_data_s = '{x0: req_x0, y0: req_y0, x1: req_x1, y1: req_y1, color: req_color};
  assign req_ready   = !full_s;
  assign push_s      = req_valid && !full_s;

  line_req_fifo #(
    .DEPTH (DEPTH),
    .T     (line_req_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next-state logic: pop a queued line when idle or when the drawer finishes.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = DRAW;
      end
      DRAW: begin
        if (ld_finished) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_s = LOAD;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = DRAW;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Current-line registers only change on a pop, so they hold through LOAD and DRAW.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_r <= {LINE_REQ_W{1'b0}};
    end else if (pop_s) begin
      cur_r <= head_s;
    end else begin
      cur_r <= cur_r;
    end
  end

  // Reset is folded into the strobes so nothing leaks out during the reset cycle.
  assign ld_reset  = reset || (state_r == LOAD);
  assign ld_x0     = cur_r.x0;
  assign ld_y0     = cur_r.y0;
  assign ld_x1     = cur_r.x1;
  assign ld_y1     = cur_r.y1;
  assign pix_valid = !reset && (state_r == DRAW) && !ld_finished;
  assign pix_x     = ld_x;
  assign pix_y     = ld_y;
  assign pix_color = cur_r.color;
  assign busy      = !reset && ((state_r != IDLE) || !empty_s);

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: a behavioural line drawer, a
// lifetime-based reference model checked every cycle, and directed scenarios.
module tb_line_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_x0, req_y0, req_x1, req_y1;
  logic        req_color;
  logic        ld_reset;
  logic [10:0] ld_x0, ld_y0, ld_x1, ld_y1;
  logic [10:0] ld_x, ld_y;
  logic        ld_finished;
  logic        pix_valid;
  logic [10:0] pix_x, pix_y;
  logic        pix_color;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {int x0; int y0; int x1; int y1; int c;} mreq_t;
  typedef struct {int cyc; int x; int y; int c;} ev_t;

  mreq_t mq[$];
  mreq_t cur;
  int    slot = -1;
  ev_t   evq[$];

  line_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_color(req_color), .ld_reset(ld_reset),
    .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y), .ld_finished(ld_finished),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Floor division for a positive divisor.
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Number of steps along the major axis (pixel count minus one).
  function automatic int line_len(input int x0, input int y0, input int x1, input int y1);
    int ax, ay;
    ax = (x1 > x0) ? x1 - x0 : x0 - x1;
    ay = (y1 > y0) ? y1 - y0 : y0 - y1;
    return (ay > ax) ? ay : ax;
  endfunction

  // Pixel i of a line walked along the increasing major axis, minor axis floored.
  function automatic int pix_coord(input int x0, input int y0, input int x1, input int y1,
                                   input int i, input bit want_y);
    int ax, ay, pa, sa, sb, n, p, s;
    ax = (x1 > x0) ? x1 - x0 : x0 - x1;
    ay = (y1 > y0) ? y1 - y0 : y0 - y1;
    if (ay > ax) begin
      if (y0 <= y1) begin pa = y0; sa = x0; sb = x1; end
      else begin pa = y1; sa = x1; sb = x0; end
      n = ay;
      p = pa + i;
      s = sa + fdiv((sb - sa) * i, n);
      return want_y ? p : s;
    end else begin
      if (x0 <= x1) begin pa = x0; sa = y0; sb = y1; end
      else begin pa = x1; sa = y1; sb = y0; end
      n = ax;
      p = pa + i;
      s = (n == 0) ? sa : sa + fdiv((sb - sa) * i, n);
      return want_y ? s : p;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Downstream line drawer: restarts on ld_reset, emits one pixel per cycle, then finishes.
  int   dr_x0 = 0, dr_y0 = 0, dr_x1 = 0, dr_y1 = 0, dr_idx = 0;
  logic dr_fin = 1'b1;
  always @(posedge clk) begin
    if (ld_reset) begin
      dr_x0  <= int'(ld_x0);
      dr_y0  <= int'(ld_y0);
      dr_x1  <= int'(ld_x1);
      dr_y1  <= int'(ld_y1);
      dr_idx <= 0;
      dr_fin <= 1'b0;
    end else if (!dr_fin) begin
      if (dr_idx >= line_len(dr_x0, dr_y0, dr_x1, dr_y1)) dr_fin <= 1'b1;
      else dr_idx <= dr_idx + 1;
    end
  end
  always_comb begin
    ld_x = 11'(pix_coord(dr_x0, dr_y0, dr_x1, dr_y1, dr_idx, 1'b0));
    ld_y = 11'(pix_coord(dr_x0, dr_y0, dr_x1, dr_y1, dr_idx, 1'b1));
  end
  assign ld_finished = dr_fin;

  // Reference model and per-cycle compare. A line's lifetime is slot 0 (load),
  // slots 1..len+1 (pixels), slot len+2 (drawer finished).
  initial begin
    bit acc;
    bit exp_pv;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        slot = -1;
      end else begin
        acc = req_valid && (mq.size() < DEPTH);
        if (slot < 0) begin
          if (mq.size() > 0) begin cur = mq.pop_front(); slot = 0; end
        end else if (slot == line_len(cur.x0, cur.y0, cur.x1, cur.y1) + 2) begin
          if (mq.size() > 0) begin cur = mq.pop_front(); slot = 0; end
          else slot = -1;
        end else begin
          slot++;
        end
        if (acc) mq.push_back('{int'(req_x0), int'(req_y0), int'(req_x1), int'(req_y1), int'(req_color)});
      end
      cyc++;
      @(negedge clk);
      exp_pv = !reset && (slot >= 1) && (slot <= line_len(cur.x0, cur.y0, cur.x1, cur.y1) + 1);
      chk("pix_valid", pix_valid, exp_pv);
      chk("busy", busy, !reset && ((slot >= 0) || (mq.size() > 0)));
      chk("req_ready", req_ready, mq.size() < DEPTH);
      chk("ld_reset", ld_reset, reset || (slot == 0));
      if (exp_pv) begin
        chk("pix_x", pix_x, pix_coord(cur.x0, cur.y0, cur.x1, cur.y1, slot - 1, 1'b0));
        chk("pix_y", pix_y, pix_coord(cur.x0, cur.y0, cur.x1, cur.y1, slot - 1, 1'b1));
        chk("pix_color", pix_color, cur.c);
      end
      if (!reset && slot >= 0) begin
        chk("ld_x0", ld_x0, cur.x0);
        chk("ld_y0", ld_y0, cur.y0);
        chk("ld_x1", ld_x1, cur.x1);
        chk("ld_y1", ld_y1, cur.y1);
      end
      if (pix_valid) evq.push_back('{cyc, int'(pix_x), int'(pix_y), int'(pix_color)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request for one edge; caller sits just after a rising edge.
  task automatic send(input int x0, input int y0, input int x1, input int y1, input int c);
    req_x0 = 11'(x0); req_y0 = 11'(y0); req_x1 = 11'(x1); req_y1 = 11'(y1);
    req_color = c[0];
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) until the block goes idle; returns on a falling edge.
  task automatic wait_idle(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("wait_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_at;
    int ex[8];
    int ey[8];
    reset = 1'b1; req_valid = 1'b0; req_color = 1'b0;
    req_x0 = 11'd0; req_y0 = 11'd0; req_x1 = 11'd0; req_y1 = 11'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_reset", ld_reset, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);
    tick();

    // Horizontal line, latency and termination.
    evq.delete();
    n_at = cyc + 1;
    send(0, 0, 3, 0, 1);
    wait_idle(50);
    chk("h_pix_valid_end", pix_valid, 0);
    chk("h_count", evq.size(), 4);
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      chk("h_x", evq[i].x, i);
      chk("h_y", evq[i].y, 0);
      chk("h_cyc", evq[i].cyc, n_at + 2 + i);
      chk("h_color", evq[i].c, 1);
    end
    tick();

    // Two back-to-back lines, reversed endpoints, two-cycle gap.
    evq.delete();
    send(3, 3, 0, 0, 1);
    send(5, 0, 2, 2, 0);
    wait_idle(60);
    ex = '{0, 1, 2, 3, 2, 3, 4, 5};
    ey = '{0, 1, 2, 3, 2, 1, 0, 0};
    chk("b2b_count", evq.size(), 8);
    for (int i = 0; i < 8 && i < evq.size(); i++) begin
      chk("b2b_x", evq[i].x, ex[i]);
      chk("b2b_y", evq[i].y, ey[i]);
      chk("b2b_color", evq[i].c, (i < 4) ? 1 : 0);
    end
    if (evq.size() >= 5) chk("b2b_gap", evq[4].cyc - evq[3].cyc, 3);
    tick();

    // Zero-length line.
    evq.delete();
    send(7, 7, 7, 7, 1);
    wait_idle(30);
    chk("dot_count", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("dot_x", evq[0].x, 7);
      chk("dot_y", evq[0].y, 7);
    end
    tick();

    // Fill the FIFO while a long line draws; a fifth offer must be dropped.
    evq.delete();
    send(0, 0, 100, 0, 1);
    repeat (4) tick();
    send(1, 1, 4, 2, 0);
    send(10, 10, 10, 13, 1);
    send(2, 0, 0, 3, 0);
    send(6, 6, 6, 6, 1);
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    tick();
    send(20, 20, 21, 21, 0);
    wait_idle(400);
    chk("fill_count", evq.size(), 114);
    if (evq.size() == 114) begin
      chk("fill_l1_first_x", evq[101].x, 1);
      chk("fill_l1_color", evq[101].c, 0);
      chk("fill_last_x", evq[113].x, 6);
      chk("fill_last_y", evq[113].y, 6);
      chk("fill_last_color", evq[113].c, 1);
    end
    tick();

    // Reset mid-line with two requests queued.
    send(0, 0, 100, 0, 1);
    repeat (8) tick();
    send(1, 2, 3, 4, 0);
    send(5, 6, 7, 8, 1);
    repeat (3) tick();
    reset = 1'b1;
    evq.delete();
    @(negedge clk);
    chk("mid_rst_pix_valid", pix_valid, 0);
    chk("mid_rst_ld_reset", ld_reset, 1);
    chk("mid_rst_busy", busy, 0);
    tick();
    @(negedge clk);
    chk("mid_rst_ld_reset2", ld_reset, 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_ready", req_ready, 1);
    chk("after_rst_ld_reset", ld_reset, 0);
    repeat (30) tick();
    chk("after_rst_no_pixels", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
